// File: rtl/instr_sequencer_if.sv
// Handshake and strobe bundle between the instruction sequencer and the ARM16 datapath.
// The sequencer takes the master modport; the datapath or stimulus side takes slave.
interface instr_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic             step;
    logic [1:0]       ir_class;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             out_ramnotalu;
    logic             ir_load;
    logic             pc_count;
    logic             reg_load;
    logic             exec;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  run, step, ir_class, mem_ready,
        output mem_req, mem_write, out_ramnotalu, ir_load, pc_count, reg_load,
               exec, halted, fault, retired
    );

    modport slave (
        output run, step, ir_class, mem_ready,
        input  mem_req, mem_write, out_ramnotalu, ir_load, pc_count, reg_load,
               exec, halted, fault, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-state instruction-cycle controller (HALT/FETCH/EXEC/MEM) for the ARM16 datapath,
// with ready-based memory waits, single-step control, timeout fault and retired counter.
module instr_sequencer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    instr_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10,
        S_MEM   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDR = 2'b01,
        CLS_STR = 2'b10,
        CLS_BRL = 2'b11
    } ir_class_e;

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Timeout fires in the cycle whose closing edge would be the MAX_WAIT-th stalled edge.
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    state_e           state_q;
    logic             step_flag_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic             fault_q;
    logic [CNT_W-1:0] retired_q;

    ir_class_e cls;
    logic      is_mem_cls;
    logic      mem_req;
    logic      mem_write;
    logic      out_ramnotalu;
    logic      ir_load;
    logic      pc_count;
    logic      reg_load;
    logic      complete;
    logic      timeout;

    assign cls        = ir_class_e'(bus.ir_class);
    assign is_mem_cls = (cls == CLS_LDR) || (cls == CLS_STR);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        out_ramnotalu = 1'b0;
        ir_load       = 1'b0;
        pc_count      = 1'b0;
        reg_load      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req       = 1'b1;
                out_ramnotalu = 1'b1;
                ir_load       = bus.mem_ready;
                pc_count      = bus.mem_ready;
            end
            S_EXEC: begin
                reg_load = !is_mem_cls;
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_write = (cls == CLS_STR);
                if (bus.mem_ready && (cls == CLS_LDR)) begin
                    reg_load      = 1'b1;
                    out_ramnotalu = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign complete = ((state_q == S_EXEC) && !is_mem_cls) ||
                      ((state_q == S_MEM) && bus.mem_ready);
    assign timeout  = (MAX_WAIT != 0) && mem_req && !bus.mem_ready &&
                      (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
            state_q     <= S_HALT;
            step_flag_q <= 1'b0;
            wait_cnt_q  <= '0;
            fault_q     <= 1'b0;
            retired_q   <= '0;
        end else begin
            unique case (state_q)
                S_HALT: begin
                    if (!fault_q && (bus.run || bus.step)) begin
                        state_q     <= S_FETCH;
                        step_flag_q <= !bus.run;
                        wait_cnt_q  <= '0;
                    end
                end
                S_FETCH, S_MEM: begin
                    if (timeout) begin
                        fault_q     <= 1'b1;
                        state_q     <= S_HALT;
                        step_flag_q <= 1'b0;
                    end else if (!bus.mem_ready) begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end else if (state_q == S_FETCH) begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem_cls) begin
                        state_q    <= S_MEM;
                        wait_cnt_q <= '0;
                    end
                end
                default: begin
                end
            endcase

            // Completion overrides the per-state branch: retire, then free-run or stop.
            if (complete) begin
                retired_q <= retired_q + CNT_W'(1);
                if (bus.run && !step_flag_q) begin
                    state_q    <= S_FETCH;
                    wait_cnt_q <= '0;
                end else begin
                    state_q     <= S_HALT;
                    step_flag_q <= 1'b0;
                end
            end
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_write     = mem_write;
    assign bus.out_ramnotalu = out_ramnotalu;
    assign bus.ir_load       = ir_load;
    assign bus.pc_count      = pc_count;
    assign bus.reg_load      = reg_load;
    assign bus.exec          = (state_q == S_EXEC) || (state_q == S_MEM);
    assign bus.halted        = (state_q == S_HALT);
    assign bus.fault         = fault_q;
    assign bus.retired       = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a phase-queue reference model.
module tb_instr_sequencer;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_sequencer_if #(.CNT_W(CNT_W)) bus ();

    instr_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the instruction in flight is a queue of remaining phases.
    typedef enum int {PH_F, PH_E, PH_M} phase_e;
    phase_e     ph_q[$];
    bit         fault_m;
    bit         step_m;
    int         waits_m;
    int         retired_m;
    logic [1:0] cls_cur;
    logic [1:0] cls_plan[$];

    logic [31:0] trace_v;
    logic [31:0] mw_mask;
    logic [31:0] irl_mask;
    int          cyc;

    task automatic model_reset();
        ph_q.delete();
        fault_m   = 1'b0;
        step_m    = 1'b0;
        waits_m   = 0;
        retired_m = 0;
    endtask

    task automatic model_complete(input logic run);
        retired_m = (retired_m + 1) % (1 << CNT_W);
        if (run && !step_m) begin
            ph_q.push_back(PH_F);
            ph_q.push_back(PH_E);
            waits_m = 0;
        end else begin
            step_m = 1'b0;
        end
    endtask

    task automatic model_step(input logic run, input logic step, input logic [1:0] cls,
                              input logic rdy);
        phase_e h;
        if (ph_q.size() == 0) begin
            if (!fault_m && (run || step)) begin
                ph_q.push_back(PH_F);
                ph_q.push_back(PH_E);
                step_m  = !run;
                waits_m = 0;
            end
        end else begin
            h = ph_q[0];
            if (h == PH_E) begin
                void'(ph_q.pop_front());
                if (cls == 2'd1 || cls == 2'd2) begin
                    ph_q.push_back(PH_M);
                    waits_m = 0;
                end else begin
                    model_complete(run);
                end
            end else if (rdy) begin
                void'(ph_q.pop_front());
                if (h == PH_M) model_complete(run);
            end else begin
                waits_m++;
                if (MAX_WAIT != 0 && waits_m == MAX_WAIT) begin
                    fault_m = 1'b1;
                    step_m  = 1'b0;
                    ph_q.delete();
                end
            end
        end
    endtask

    // {mem_req, mem_write, out_ramnotalu, ir_load, pc_count, reg_load, exec, halted, fault}
    function automatic logic [8:0] exp_vec(input logic [1:0] cls, input logic rdy);
        logic f, e, m, ld;
        f = 1'b0; e = 1'b0; m = 1'b0;
        if (ph_q.size() != 0) begin
            f = (ph_q[0] == PH_F);
            e = (ph_q[0] == PH_E);
            m = (ph_q[0] == PH_M);
        end
        ld = m && (cls == 2'd1) && rdy;
        return {f | m, m && (cls == 2'd2), f | ld, f && rdy, f && rdy,
                (e && (cls == 2'd0 || cls == 2'd3)) | ld, e | m, ph_q.size() == 0, fault_m};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {bus.mem_req, bus.mem_write, bus.out_ramnotalu, bus.ir_load, bus.pc_count,
                bus.reg_load, bus.exec, bus.halted, bus.fault};
    endfunction

    function automatic logic [31:0] seq_code(input string s);
        logic [31:0] r;
        logic [1:0]  c;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "F":     c = 2'd1;
                "E":     c = 2'd2;
                "M":     c = 2'd3;
                default: c = 2'd0;
            endcase
            r = (r << 2) | 32'(c);
        end
        return r;
    endfunction

    task automatic trace_clear();
        trace_v  = '0;
        mw_mask  = '0;
        irl_mask = '0;
        cyc      = 0;
    endtask

    // Called just after a rising edge; leaves just after the next rising edge.
    task automatic tick(input logic run, input logic step, input logic rdy);
        logic [1:0] code;
        if (ph_q.size() != 0 && ph_q[0] == PH_E)
            cls_cur = (cls_plan.size() != 0) ? cls_plan.pop_front() : 2'($urandom_range(0, 3));
        bus.run       = run;
        bus.step      = step;
        bus.mem_ready = rdy;
        bus.ir_class  = cls_cur;
        @(negedge clk);
        code = bus.halted ? 2'd0 : (bus.exec ? (bus.mem_req ? 2'd3 : 2'd2)
                                             : (bus.mem_req ? 2'd1 : 2'd0));
        trace_v  = (trace_v << 2) | 32'(code);
        mw_mask  = mw_mask  | (32'(bus.mem_write) << cyc);
        irl_mask = irl_mask | (32'(bus.ir_load) << cyc);
        cyc++;
        check("outputs", 32'(obs_vec()), 32'(exp_vec(cls_cur, rdy)));
        check("retired", 32'(bus.retired), 32'(retired_m));
        model_step(run, step, cls_cur, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_outputs", 32'(obs_vec()), 32'(9'b0_0000_0010));
        check("reset_retired", 32'(bus.retired), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int low_pct;
        bus.ir_class = 2'd0;
        cls_cur      = 2'd0;
        trace_clear();
        do_reset();

        // Class stream 00,01,10,11 free-running, run dropped during the last instruction.
        cls_plan = '{2'd0, 2'd1, 2'd2, 2'd3};
        tick(1'b1, 1'b0, 1'b1);
        trace_clear();
        for (int i = 0; i < 10; i++) tick(i < 8, 1'b0, 1'b1);
        check("stream_seq", trace_v, seq_code("FEFEMFEMFE"));
        check("stream_retired", 32'(bus.retired), 32'd4);
        check("stream_memwrite", mw_mask, 32'h80);
        check("stream_halted", 32'(bus.halted), 32'd1);

        // Single step of a load, then a second step with run rising mid-instruction.
        trace_clear();
        cls_plan = '{2'd1};
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1);
        check("step_seq", trace_v, seq_code("HFEMH"));
        check("step_retired", 32'(bus.retired), 32'd5);
        trace_clear();
        cls_plan = '{2'd2};
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("step2_seq", trace_v, seq_code("HFEMH"));
        check("step2_retired", 32'(bus.retired), 32'd6);

        // Fetch stalled three cycles, well short of the timeout.
        trace_clear();
        cls_plan = '{2'd0};
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        check("stall_seq", trace_v, seq_code("HFFFFEH"));
        check("stall_irload", irl_mask, 32'h10);
        check("stall_fault", 32'(bus.fault), 32'd0);

        // Asynchronous reset while a load waits in MEM.
        cls_plan = '{2'd1};
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("pre_rst_memreq", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_memreq", 32'(bus.mem_req), 32'd0);
        check("rst_outputs", 32'(obs_vec()), 32'(9'b0_0000_0010));
        check("rst_retired", 32'(bus.retired), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        trace_clear();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        check("rst_restart_seq", trace_v, seq_code("HF"));

        // Counter wrap: 17 ALU instructions with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) cls_plan.push_back(2'd0);
        tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 34; i++) tick(i < 32, 1'b0, 1'b1);
        check("wrap_retired", 32'(bus.retired), 32'd1);

        // Timeout in MEM: fault is sticky until reset.
        cls_plan = '{2'd1};
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b0, 1'b0);
        check("timeout_early", 32'(bus.fault), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check("timeout_fault", 32'(bus.fault), 32'd1);
        check("timeout_halted", 32'(bus.halted), 32'd1);
        trace_clear();
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("fault_hold_seq", trace_v, seq_code("HHH"));

        // Randomized traffic; the last block stalls heavily to reach timeouts.
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            cls_plan.delete();
            low_pct = (blk == 3) ? 92 : 25;
            for (int i = 0; i < 600; i++) begin
                if (blk == 2)
                    tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                         1'($urandom_range(0, 99) >= low_pct));
                else
                    tick(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) == 0),
                         1'($urandom_range(0, 99) >= low_pct));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
